// File: rtl/instr_mem_fetch.sv
// Writable instruction memory with a valid/ready fetch channel, a 1-cycle read and a 2-entry response FIFO.
// Optional INSTR_MEM_PARITY_EN adds a stored even-parity bit per word and an rsp_perr output.
module instr_mem_fetch #(
  parameter int                DATA_W        = 32,
  parameter int                ADDR_W        = 16,
  parameter int                DEPTH         = 64,
  parameter logic [DATA_W-1:0] DEFAULT_INSTR = 32'hD60003E0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_oob,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              busy
`ifdef INSTR_MEM_PARITY_EN
  ,
  output logic              rsp_perr
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
`ifdef INSTR_MEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  function automatic logic [WORD_W-1:0] pack_word(input logic [DATA_W-1:0] d);
`ifdef INSTR_MEM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  logic [0:0]        state;
  logic [IDX_W-1:0]  init_ptr;
  logic [WORD_W-1:0] mem [DEPTH];

  logic              ld_in_range, rd_in_range, ld_wr;
  logic [WORD_W-1:0] rd_word;

  logic              vld_p0, pop;
  logic [DATA_W-1:0] data_p0;
  logic              oob_p0, perr_p0;

  logic              head, tail;
  logic [1:0]        count;
  logic [DATA_W-1:0] fifo_data [2];
  logic              fifo_oob  [2];
  logic              fifo_perr [2];

  assign ld_in_range = ({1'b0, ld_addr} < DEPTH_EXT);
  assign rd_in_range = ({1'b0, req_addr} < DEPTH_EXT);
  assign ld_wr       = (state == RUN) && ld_en && ld_in_range;

  assign busy      = (state == INIT);
  assign req_ready = (state == RUN) && !ld_en && (count < 2'd2);
  assign rsp_valid = (count != 2'd0);
  assign rsp_data  = fifo_data[head];
  assign rsp_oob   = fifo_oob[head];
`ifdef INSTR_MEM_PARITY_EN
  assign rsp_perr  = fifo_perr[head];
`endif

  // Array: no reset, INIT rewrites every entry after each reset release.
  always_ff @(posedge clk) begin
    if (state == INIT)
      mem[init_ptr] <= pack_word(DEFAULT_INSTR);
    else if (ld_wr)
      mem[ld_addr[IDX_W-1:0]] <= pack_word(ld_data);
  end

  // Stage p0: read the array at the accepting edge and push straight into the FIFO.
  assign vld_p0  = req_valid && req_ready;
  assign pop     = rsp_valid && rsp_ready;
  assign rd_word = mem[req_addr[IDX_W-1:0]];
  assign data_p0 = rd_in_range ? rd_word[DATA_W-1:0] : DEFAULT_INSTR;
  assign oob_p0  = !rd_in_range;
  assign perr_p0 = rd_in_range && (^rd_word) && (WORD_W > DATA_W);
  // Tail never aliases head while the head entry is valid, so the head holds still under backpressure.
  assign tail    = head ^ count[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      init_ptr <= '0;
      head     <= 1'b0;
      count    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= DEFAULT_INSTR;
        fifo_oob[i]  <= 1'b0;
        fifo_perr[i] <= 1'b0;
      end
    end else begin
      if (state == INIT) begin
        if (init_ptr == LAST_IDX)
          state <= RUN;
        else
          init_ptr <= init_ptr + 1'b1;
      end
      if (vld_p0) begin
        fifo_data[tail] <= data_p0;
        fifo_oob[tail]  <= oob_p0;
        fifo_perr[tail] <= perr_p0;
      end
      if (pop)
        head <= ~head;
      case ({vld_p0, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
